// File: rtl/snake_pkg.sv
// Shared types for the snake head controller: travel directions, game states
// and the reverse-direction test used by key capture.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    LEFT  = 2'b01,
    RIGHT = 2'b10,
    DOWN  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10
  } state_t;

  // Opposite directions differ in both bits (up/down = 00/11, left/right = 01/10).
  function automatic logic is_reverse(dir_t a, dir_t b);
    return (a ^ b) == 2'b11;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Free-running move prescaler: counts 0..TICKS-1 while enabled and is held at 0
// otherwise; tc marks the last tick of each period.
module step_prescaler #(
  parameter int TICKS = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tc
);

  localparam int CW = (TICKS > 2) ? $clog2(TICKS) : 1;

  logic [CW-1:0] count;

  assign tc = en && (count == CW'(TICKS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (!en || tc)
      count <= '0;
    else
      count <= count + 1'b1;
  end

endmodule

// File: rtl/snake_head_ctrl.sv
// Snake head controller: key capture, periodic head moves, apple growth and
// wall collision for a ROWS x COLS LED matrix.
module snake_head_ctrl
  import snake_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int STEP_TICKS = 256,
  parameter int SIZE_W     = 6,
  parameter int MAX_SIZE   = 63,
  parameter int START_SIZE = 1,
  parameter int START_ROW  = 4,
  parameter int START_COL  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     key_up,
  input  logic                     key_left,
  input  logic                     key_right,
  input  logic                     key_down,
  input  logic [$clog2(ROWS)-1:0]  apple_row,
  input  logic [$clog2(COLS)-1:0]  apple_col,
  output logic [1:0]               next_dir,
  output logic [1:0]               dir_q,
  output logic [$clog2(ROWS)-1:0]  head_row,
  output logic [$clog2(COLS)-1:0]  head_col,
  output logic [ROWS*COLS-1:0]     head_onehot,
  output logic                     step,
  output logic [SIZE_W-1:0]        size,
  output logic                     apple_eaten,
  output logic                     game_over,
  output logic                     running
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  state_t          state, state_d;
  dir_t            next_dir_r, dir_r;
  logic            move, wall, hit;
  logic [RW-1:0]   cand_row;
  logic [CW-1:0]   cand_col;
  logic            key_valid, key_ok;
  dir_t            key_dir, ref_dir;

  step_prescaler #(.TICKS(STEP_TICKS)) u_prescaler (
    .clk (clk),
    .rst (reset),
    .en  (state == RUN),
    .tc  (move)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cand_row = head_row;
    cand_col = head_col;
    wall     = 1'b0;
    case (next_dir_r)
      UP:    if (head_row == '0)             wall = 1'b1; else cand_row = head_row - 1'b1;
      DOWN:  if (head_row == RW'(ROWS - 1))  wall = 1'b1; else cand_row = head_row + 1'b1;
      LEFT:  if (head_col == '0)             wall = 1'b1; else cand_col = head_col - 1'b1;
      RIGHT: if (head_col == CW'(COLS - 1))  wall = 1'b1; else cand_col = head_col + 1'b1;
    endcase
  end

  assign hit = (cand_row == apple_row) && (cand_col == apple_col);

  // Priority up > left > right > down; on a move edge the key is judged
  // against the direction that move commits.
  always_comb begin
    key_valid = key_up | key_left | key_right | key_down;
    if (key_up)         key_dir = UP;
    else if (key_left)  key_dir = LEFT;
    else if (key_right) key_dir = RIGHT;
    else                key_dir = DOWN;
  end

  assign ref_dir = move ? next_dir_r : dir_r;
  assign key_ok  = key_valid && (state != OVER) && !is_reverse(key_dir, ref_dir);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start)        state_d = RUN;
      RUN:     if (move && wall) state_d = OVER;
      OVER:    if (start)        state_d = RUN;
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_row    <= RW'(START_ROW);
      head_col    <= CW'(START_COL);
      size        <= SIZE_W'(START_SIZE);
      next_dir_r  <= RIGHT;
      dir_r       <= RIGHT;
      step        <= 1'b0;
      apple_eaten <= 1'b0;
    end else begin
      step        <= 1'b0;
      apple_eaten <= 1'b0;
      if (state == OVER && start) begin
        head_row   <= RW'(START_ROW);
        head_col   <= CW'(START_COL);
        size       <= SIZE_W'(START_SIZE);
        next_dir_r <= RIGHT;
        dir_r      <= RIGHT;
      end else begin
        if (move) begin
          dir_r <= next_dir_r;
          if (!wall) begin
            head_row <= cand_row;
            head_col <= cand_col;
            step     <= 1'b1;
            if (hit) begin
              apple_eaten <= 1'b1;
              if (size != SIZE_W'(MAX_SIZE)) size <= size + 1'b1;
            end
          end
        end
        if (key_ok) next_dir_r <= key_dir;
      end
    end
  end

  always_comb begin
    int idx;
    idx = int'(head_row) * COLS + int'(head_col);
    head_onehot = '0;
    for (int i = 0; i < ROWS * COLS; i++) head_onehot[i] = (i == idx);
  end

  assign next_dir  = next_dir_r;
  assign dir_q     = dir_r;
  assign running   = (state == RUN);
  assign game_over = (state == OVER);

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Randomised scoreboard bench for snake_head_ctrl against a grid-level model
// of the game rules, plus directed scenarios for walls, keys, apples and reset.
module tb_snake_head_ctrl;

  localparam int ST = 4;
  localparam int NR = 8;
  localparam int NC = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, key_up, key_left, key_right, key_down;
  logic [2:0]  apple_row, apple_col;
  logic [1:0]  next_dir, dir_q;
  logic [2:0]  head_row, head_col;
  logic [63:0] head_onehot;
  logic        step, apple_eaten, game_over, running;
  logic [5:0]  size;

  snake_head_ctrl #(.STEP_TICKS(ST)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .key_up      (key_up),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_down    (key_down),
    .apple_row   (apple_row),
    .apple_col   (apple_col),
    .next_dir    (next_dir),
    .dir_q       (dir_q),
    .head_row    (head_row),
    .head_col    (head_col),
    .head_onehot (head_onehot),
    .step        (step),
    .size        (size),
    .apple_eaten (apple_eaten),
    .game_over   (game_over),
    .running     (running)
  );

  always #5 clk = ~clk;

  typedef struct {int r; int c; int sz; bit eat; int dq;} move_t;
  typedef struct {int r; int c;} over_t;

  move_t exp_q[$];
  over_t over_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Game model: st 0 idle / 1 run / 2 over; directions 0 up,1 left,2 right,3 down.
  int m_st, m_tick, m_r, m_c, m_size, m_nd, m_dq;
  int dr[4] = '{-1, 0, 0, 1};
  int dc[4] = '{0, -1, 1, 0};

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_grid(int r, int c);
    return r >= 0 && r < NR && c >= 0 && c < NC;
  endfunction

  task automatic model_reset();
    m_st = 0; m_tick = 0; m_r = 4; m_c = 4; m_size = 1; m_nd = 2; m_dq = 2;
  endtask

  task automatic model_edge(bit s, bit [3:0] k, int ar, int ac);
    int st = m_st, tick = m_tick, r = m_r, c = m_c, sz = m_size, nd = m_nd, dq = m_dq;
    int nr, nc, sel, ref_d;
    bit mv;
    mv = (m_st == 1) && (m_tick == ST - 1);
    if (m_st == 1) tick = (m_tick + 1) % ST;
    else if (s) begin
      st = 1; tick = 0;
      if (m_st == 2) begin r = 4; c = 4; sz = 1; nd = 2; dq = 2; end
    end
    if (mv) begin
      dq = m_nd;
      nr = m_r + dr[m_nd];
      nc = m_c + dc[m_nd];
      if (!in_grid(nr, nc)) begin
        st = 2; tick = 0;
        over_q.push_back('{m_r, m_c});
      end else begin
        bit eat = (nr == ar) && (nc == ac);
        r = nr; c = nc;
        if (eat && sz < 63) sz = sz + 1;
        exp_q.push_back('{nr, nc, sz, eat, m_nd});
      end
    end
    if (m_st != 2) begin
      ref_d = mv ? m_nd : m_dq;
      sel = -1;
      for (int i = 0; i < 4; i++) if (k[i] && sel < 0) sel = i;
      if (sel >= 0 && sel + ref_d != 3) nd = sel;
    end
    m_st = st; m_tick = tick; m_r = r; m_c = c; m_size = sz; m_nd = nd; m_dq = dq;
  endtask

  // k: bit0 up, bit1 left, bit2 right, bit3 down
  task automatic cyc(bit s, bit [3:0] k, int ar, int ac);
    start = s;
    key_up = k[0]; key_left = k[1]; key_right = k[2]; key_down = k[3];
    apple_row = 3'(ar);
    apple_col = 3'(ac);
    model_edge(s, k, ar, ac);
    @(posedge clk); #1;
    start = 1'b0;
    {key_up, key_left, key_right, key_down} = 4'b0;
    check("next_dir", 64'(next_dir), 64'(m_nd));
    check("dir_q", 64'(dir_q), 64'(m_dq));
    check("running", 64'(running), 64'(m_st == 1));
    check("game_over", 64'(game_over), 64'(m_st == 2));
    check("size", 64'(size), 64'(m_size));
  endtask

  task automatic check_reset_values(string tag);
    logic [63:0] oh;
    oh = 64'd1 << 36;
    check({tag, "_head_row"}, 64'(head_row), 64'd4);
    check({tag, "_head_col"}, 64'(head_col), 64'd4);
    check({tag, "_onehot"}, head_onehot, oh);
    check({tag, "_size"}, 64'(size), 64'd1);
    check({tag, "_next_dir"}, 64'(next_dir), 64'd2);
    check({tag, "_dir_q"}, 64'(dir_q), 64'd2);
    check({tag, "_step"}, 64'(step), 64'd0);
    check({tag, "_eaten"}, 64'(apple_eaten), 64'd0);
    check({tag, "_running"}, 64'(running), 64'd0);
    check({tag, "_game_over"}, 64'(game_over), 64'd0);
  endtask

  // Asserts reset between edges while the prescaler is mid-count.
  task automatic hard_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    exp_q.delete();
    over_q.delete();
    model_reset();
    #1;
    check_reset_values("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor: pops a scoreboard entry for every step and every entry into OVER.
  bit go_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      go_prev = 1'b0;
    end else begin
      if (step) begin
        if (exp_q.size() == 0) begin
          check("unexpected_step", 64'(step), 64'd0);
        end else begin
          move_t e;
          e = exp_q.pop_front();
          check("step_head_row", 64'(head_row), 64'(e.r));
          check("step_head_col", 64'(head_col), 64'(e.c));
          check("step_onehot", head_onehot, 64'd1 << (e.r * NC + e.c));
          check("step_size", 64'(size), 64'(e.sz));
          check("step_eaten", 64'(apple_eaten), 64'(e.eat));
          check("step_dir_q", 64'(dir_q), 64'(e.dq));
        end
      end else begin
        check("eaten_without_step", 64'(apple_eaten), 64'd0);
      end
      if (game_over && !go_prev) begin
        if (over_q.size() == 0) begin
          check("unexpected_over", 64'(game_over), 64'd0);
        end else begin
          over_t o;
          o = over_q.pop_front();
          check("over_head_row", 64'(head_row), 64'(o.r));
          check("over_head_col", 64'(head_col), 64'(o.c));
        end
      end
      go_prev = game_over;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ar, ac, d, cr, cc;
    bit [3:0] k;
    bit mv;

    reset = 1'b1;
    start = 1'b0;
    {key_up, key_left, key_right, key_down} = 4'b0;
    apple_row = 3'd0;
    apple_col = 3'd0;
    model_reset();
    #12;
    check_reset_values("por");
    reset = 1'b0;
    @(posedge clk); #1;

    // Straight run to the right wall, apple parked out of the way.
    cyc(1'b1, 4'b0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 4'b0, 0, 0);
    check("wall_game_over", 64'(game_over), 64'd1);
    check("wall_head_col", 64'(head_col), 64'd7);
    check("wall_no_step", 64'(step), 64'd0);

    // Restart from OVER; first move STEP_TICKS cycles later.
    cyc(1'b1, 4'b0, 0, 0);
    check("restart_head_col", 64'(head_col), 64'd4);
    check("restart_running", 64'(running), 64'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0, 0, 0);
    check("restart_no_early_step", 64'(step), 64'd0);
    cyc(1'b0, 4'b0, 0, 0);
    check("restart_first_step", 64'(step), 64'd1);
    check("restart_first_col", 64'(head_col), 64'd5);

    // Reverse key ignored, then up accepted.
    cyc(1'b0, 4'b0010, 0, 0);
    check("reverse_ignored", 64'(next_dir), 64'd2);
    cyc(1'b0, 4'b0001, 0, 0);
    cyc(1'b0, 4'b0, 0, 0);
    cyc(1'b0, 4'b0, 0, 0);
    check("turn_up_row", 64'(head_row), 64'd3);
    check("turn_up_dir_q", 64'(dir_q), 64'd0);

    // Up+down together -> up; down then left before a move -> left.
    cyc(1'b0, 4'b1001, 0, 0);
    check("multi_key_prio", 64'(next_dir), 64'd0);
    cyc(1'b0, 4'b1000, 0, 0);
    cyc(1'b0, 4'b0010, 0, 0);
    cyc(1'b0, 4'b0, 0, 0);
    check("last_key_wins_col", 64'(head_col), 64'd4);
    check("last_key_wins_dir", 64'(dir_q), 64'd1);

    // Apple right in front of the start cell.
    hard_reset();
    cyc(1'b1, 4'b0, 4, 5);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'b0, 4, 5);
    check("apple_eaten_first", 64'(apple_eaten), 64'd1);
    check("apple_size_2", 64'(size), 64'd2);

    // Steer clear of walls and feed every move until size saturates.
    for (int i = 0; i < 320; i++) begin
      mv = (m_st == 1) && (m_tick == ST - 1);
      cr = m_r + dr[m_nd];
      cc = m_c + dc[m_nd];
      k = 4'b0;
      if (!mv) begin
        if (!in_grid(cr, cc)) begin
          for (int j = 3; j >= 0; j--)
            if (j + m_dq != 3 && in_grid(m_r + dr[j], m_c + dc[j])) d = j;
          k = 4'(1 << d);
        end else if ($urandom_range(0, 3) == 0) begin
          d = $urandom_range(0, 3);
          if (d + m_dq != 3 && in_grid(m_r + dr[d], m_c + dc[d])) k = 4'(1 << d);
        end
      end
      cyc(1'b0, k, in_grid(cr, cc) ? cr : 0, in_grid(cr, cc) ? cc : 0);
    end
    check("size_saturated", 64'(size), 64'd63);
    check("still_running", 64'(running), 64'd1);

    // Random play with restarts and one asynchronous reset in the middle.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) hard_reset();
      k  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      ar = $urandom_range(0, NR - 1);
      ac = $urandom_range(0, NC - 1);
      cyc($urandom_range(0, 15) == 0, k, ar, ac);
    end

    @(negedge clk); #1;
    check("steps_drained", 64'(exp_q.size()), 64'd0);
    check("overs_drained", 64'(over_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_head_ctrl.md
Name: snake_head_ctrl

Overview:
Drives the snake head across the ROWS x COLS LED matrix and acts as the producer side of the per-cell light interface. It turns debounced direction keys into the committed direction and the head position. It also generates the periodic step pulse, grows the snake size on an apple hit, and flags a wall collision. Per-cell light FSMs consume next_dir, size, step and the head one-hot to decide when to turn green.

Parameters:
ROWS, 8, matrix rows (row 0 = top)
COLS, 8, matrix columns (col 0 = left)
STEP_TICKS, 256, clk cycles per head move (>=2)
SIZE_W, 6, width of size
MAX_SIZE, 63, saturation value of size
START_SIZE, 1, size after reset/restart
START_ROW, 4, head row after reset/restart
START_COL, 4, head column after reset/restart

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin or restart game
key_up / key_left / key_right / key_down  in  1 each  one-cycle debounced key pulses
apple_row  in  $clog2(ROWS)  current apple row
apple_col  in  $clog2(COLS)  current apple column
next_dir  out  2  pending direction: 00 up, 01 left, 10 right, 11 down
dir_q  out  2  direction used for the last move
head_row  out  $clog2(ROWS)  registered head row
head_col  out  $clog2(COLS)  registered head column
head_onehot  out  ROWS*COLS  one bit set at index head_row*COLS+head_col
step  out  1  one-cycle pulse; head moved this cycle
size  out  SIZE_W  snake length
apple_eaten  out  1  one-cycle pulse, coincident with step
game_over  out  1  level; high in OVER
running  out  1  level; high in RUN

Behaviour:
- Reset (async, any time, including mid-step):
  - state IDLE; prescaler 0
  - head = (START_ROW, START_COL); size = START_SIZE
  - next_dir = dir_q = 10 (right)
  - step = apple_eaten = game_over = 0
- FSM states: IDLE, RUN, OVER.
  - IDLE: start -> RUN, prescaler cleared.
  - RUN: start ignored.
  - OVER: start reinitialises head, size, dirs and prescaler to reset values and enters RUN on the same edge.
- Prescaler: counts 0..STEP_TICKS-1 only in RUN; wraps to 0; held at 0 in IDLE/OVER.
- Key capture:
  - Active in IDLE and RUN.
  - Priority when several keys fire in one cycle: up > left > right > down.
  - A key whose direction is the reverse of dir_q is ignored (up<->down, left<->right).
  - A key equal to dir_q is accepted and has no effect.
  - Last accepted key before a step wins.
  - Keys are ignored in OVER.
- Move, on the edge where the prescaler equals STEP_TICKS-1 in RUN:
  - dir_q <= next_dir.
  - Candidate head = head moved one cell in next_dir.
  - If the candidate leaves the grid (row 0 going up, row ROWS-1 going down, col 0 going left, col COLS-1 going right): state <= OVER, head unchanged, step = 0.
  - Otherwise: head <= candidate and step = 1 for exactly one cycle.
  - If the candidate equals (apple_row, apple_col), sampled on this edge: apple_eaten = 1 with step, and size <= size+1, saturating at MAX_SIZE.
  - Latency: head, step, apple_eaten and size all change on the same edge. They are visible in the cycle after prescaler = STEP_TICKS-1.
- A key pulse on the same edge as a move: not applied to that move. It updates next_dir for the following move, checked against the new dir_q.
- head_onehot: decoded combinationally from the registered head, so it tracks head_row/head_col with zero latency.
- running = (state == RUN); game_over = (state == OVER).

Decomposition:
- Package snake_pkg:
  - typedef dir_t: 2-bit enum UP=00, LEFT=01, RIGHT=10, DOWN=11
  - typedef state_t: IDLE, RUN, OVER
  - function is_reverse(dir_t a, dir_t b)
- One sub-module, step_prescaler: counter, enable, terminal-count output. Everything else stays in this module.

Test Plan:
- Reset, start, no keys, STEP_TICKS=4 -> step every 4 cycles; head goes (4,4),(4,5),(4,6),(4,7); next move sets game_over=1, head stays (4,7), no step.
- Heading right, key_left pulse -> ignored, next_dir stays 10; then key_up -> next move lands at (3,c); dir_q becomes 00.
- key_up and key_down in the same cycle -> next_dir=00; key_down then key_left before one step -> move is left.
- Apple at (4,5), start -> first step has apple_eaten=1 and size 1->2; size forced at 63 with an apple hit stays 63.
- Async reset asserted mid-prescaler and between clock edges -> outputs immediately return to reset values (IDLE, head (4,4), size 1).
- In OVER, start -> head (4,4), size 1, dir 10, running=1; next step occurs STEP_TICKS cycles later.
